// File: rtl/atm_pkg.sv
// Shared opcode, status and FSM encodings for the ATM account arbiter.
package atm_pkg;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_BAL  = 2'b01;
  localparam logic [1:0] OP_WD   = 2'b10;
  localparam logic [1:0] OP_DEP  = 2'b11;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_INSUF = 2'b01;
  localparam logic [1:0] ST_OVF   = 2'b10;
  localparam logic [1:0] ST_BADOP = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/atm_rr_arbiter.sv
// Combinational round-robin pick: first set request at index >= i_ptr, wrapping.
module atm_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_vld
);

  int               w_pos;
  logic [PTR_W-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    w_pos = 0;
    w_j   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= N_REQ) w_pos = w_pos - N_REQ;
      w_j = PTR_W'(w_pos);
      if (!o_vld && i_req[w_j]) begin
        o_vld      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/atm_account_arbiter.sv
// Round-robin arbiter sharing one balance ledger among N_REQ ATM controllers.
// Optional completed-transaction counter is built when ATM_ARB_TXN_CNT_EN is defined.
module atm_account_arbiter
  import atm_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int BAL_W    = 16,
  parameter int INIT_BAL = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [BAL_W*N_REQ-1:0] amt,
  output logic [N_REQ-1:0]       grant,
  output logic                   done,
  output logic [1:0]             status,
  output logic [BAL_W-1:0]       rsp_balance,
  output logic [BAL_W-1:0]       balance,
  output logic                   busy,
  output logic [15:0]            txn_count
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           r_state, w_next;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] w_pick_gnt;
  logic [PTR_W-1:0] w_pick_idx;
  logic             w_pick_vld;

  logic [1:0]       r_op;
  logic [BAL_W-1:0] r_amt;
  logic [BAL_W-1:0] r_balance;
  logic [BAL_W-1:0] r_rsp;
  logic [1:0]       r_status;

  logic [1:0]       w_req_op;
  logic [BAL_W-1:0] w_req_amt;
  logic [BAL_W:0]   w_sum;
  logic [BAL_W-1:0] w_res_bal;
  logic [1:0]       w_res_st;

  atm_rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr (
    .i_req (req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_vld (w_pick_vld)
  );

  always_comb begin
    w_req_op  = OP_NONE;
    w_req_amt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick_gnt[i]) begin
        w_req_op  = op[2*i +: 2];
        w_req_amt = amt[BAL_W*i +: BAL_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_pick_vld) w_next = EXEC;
      EXEC:    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
    done = (r_state == DONE);
  end

  // Ledger evaluation of the latched request; the wide sum exposes deposit overflow
  always_comb begin
    w_sum     = {1'b0, r_balance} + {1'b0, r_amt};
    w_res_bal = r_balance;
    w_res_st  = ST_BADOP;
    case (r_op)
      OP_BAL: w_res_st = ST_OK;
      OP_WD: begin
        if (r_amt <= r_balance) begin
          w_res_bal = r_balance - r_amt;
          w_res_st  = ST_OK;
        end else begin
          w_res_st  = ST_INSUF;
        end
      end
      OP_DEP: begin
        if (w_sum[BAL_W]) begin
          w_res_st  = ST_OVF;
        end else begin
          w_res_bal = w_sum[BAL_W-1:0];
          w_res_st  = ST_OK;
        end
      end
      default: w_res_st = ST_BADOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else if (r_state == IDLE && w_pick_vld) begin
      r_grant  <= w_pick_gnt;
      r_rr_ptr <= (w_pick_idx == PTR_W'(N_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
    end else if (r_state == DONE) begin
      r_grant  <= '0;
    end
  end

  // Op and amount are captured once at grant, so later input changes cannot leak in
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_pick_vld) begin
      r_op  <= w_req_op;
      r_amt <= w_req_amt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_balance <= BAL_W'(INIT_BAL);
      r_rsp     <= '0;
      r_status  <= ST_OK;
    end else if (r_state == EXEC) begin
      r_balance <= w_res_bal;
      r_rsp     <= w_res_bal;
      r_status  <= w_res_st;
    end
  end

`ifdef ATM_ARB_TXN_CNT_EN
  logic [15:0] r_txn_cnt;

  always_ff @(posedge clk) begin
    if (reset)                                    r_txn_cnt <= '0;
    else if (r_state == EXEC && w_res_st == ST_OK) r_txn_cnt <= r_txn_cnt + 16'd1;
  end

  assign txn_count = r_txn_cnt;
`else
  assign txn_count = '0;
`endif

  assign grant       = r_grant;
  assign balance     = r_balance;
  assign rsp_balance = r_rsp;
  assign status      = r_status;

endmodule

// File: tb/tb_atm_account_arbiter.sv
// Directed bench for atm_account_arbiter: ledger ops, boundaries, arbitration, reset abort.
module tb_atm_account_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [63:0] amt;
  logic [3:0]  grant;
  logic        done;
  logic [1:0]  status;
  logic [15:0] rsp_balance;
  logic [15:0] balance;
  logic        busy;
  logic [15:0] txn_count;

  int n_checks = 0;
  int n_err    = 0;
  int exp_cnt  = 0;

  atm_account_arbiter #(.N_REQ(4), .BAL_W(16), .INIT_BAL(1000)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .op          (op),
    .amt         (amt),
    .grant       (grant),
    .done        (done),
    .status      (status),
    .rsp_balance (rsp_balance),
    .balance     (balance),
    .busy        (busy),
    .txn_count   (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cnt_exp();
`ifdef ATM_ARB_TXN_CNT_EN
    return 16'(exp_cnt);
`else
    return 16'd0;
`endif
  endfunction

  // One isolated transaction from requester idx; done is checked one edge after grant
  task automatic txn(input string tag, input int idx, input logic [1:0] o, input logic [15:0] a,
                     input logic [1:0] exp_st, input logic [15:0] exp_bal);
    req = 4'b0;
    req[idx] = 1'b1;
    op[2*idx +: 2] = o;
    amt[16*idx +: 16] = a;
    tick();
    check({tag, "_grant"}, 32'(grant), 32'(4'b1 << idx));
    check({tag, "_busy"},  32'(busy), 32'd1);
    check({tag, "_early_done"}, 32'(done), 32'd0);
    tick();
    if (exp_st == 2'b00) exp_cnt++;
    check({tag, "_done"},   32'(done), 32'd1);
    check({tag, "_status"}, 32'(status), 32'(exp_st));
    check({tag, "_rsp"},    32'(rsp_balance), 32'(exp_bal));
    check({tag, "_bal"},    32'(balance), 32'(exp_bal));
    check({tag, "_cnt"},    32'(txn_count), 32'(cnt_exp()));
    req = 4'b0;
    tick();
    check({tag, "_grant_clr"}, 32'(grant), 32'd0);
    check({tag, "_done_clr"},  32'(done), 32'd0);
    check({tag, "_busy_clr"},  32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    op    = '0;
    amt   = '0;
    tick();
    tick();
    check("rst_grant",  32'(grant), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_rsp",    32'(rsp_balance), 32'd0);
    check("rst_bal",    32'(balance), 32'd1000);
    check("rst_cnt",    32'(txn_count), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_grant", 32'(grant), 32'd0);

    txn("wd300",   0, 2'b10, 16'd300,   2'b00, 16'd700);
    txn("wd701",   0, 2'b10, 16'd701,   2'b01, 16'd700);
    txn("wd700",   0, 2'b10, 16'd700,   2'b00, 16'd0);
    txn("dep65k",  0, 2'b11, 16'd65000, 2'b00, 16'd65000);
    txn("dep600",  0, 2'b11, 16'd600,   2'b10, 16'd65000);
    txn("dep535",  0, 2'b11, 16'd535,   2'b00, 16'd65535);
    txn("badop",   2, 2'b00, 16'd5,     2'b11, 16'd65535);
    txn("wd0",     3, 2'b10, 16'd0,     2'b00, 16'd65535);

    // Winner drops req and changes amt after the grant edge; the latched 1000 applies
    req = 4'b0010;
    op[3:2] = 2'b10;
    amt[31:16] = 16'd1000;
    tick();
    check("drop_grant", 32'(grant), 32'b0010);
    req = 4'b0;
    amt[31:16] = 16'd5;
    tick();
    exp_cnt++;
    check("drop_done",   32'(done), 32'd1);
    check("drop_status", 32'(status), 32'd0);
    check("drop_bal",    32'(balance), 32'd64535);
    check("drop_cnt",    32'(txn_count), 32'(cnt_exp()));
    tick();
    check("drop_busy_clr", 32'(busy), 32'd0);

    // Reset while the withdraw is in EXEC aborts it
    req = 4'b0001;
    op[1:0] = 2'b10;
    amt[15:0] = 16'd200;
    tick();
    check("rx_grant", 32'(grant), 32'b0001);
    reset = 1'b1;
    tick();
    exp_cnt = 0;
    check("rx_done",  32'(done), 32'd0);
    check("rx_grant_clr", 32'(grant), 32'd0);
    check("rx_busy",  32'(busy), 32'd0);
    check("rx_bal",   32'(balance), 32'd1000);
    check("rx_cnt",   32'(txn_count), 32'd0);
    req = 4'b0;
    reset = 1'b0;
    tick();
    check("rx_no_done", 32'(done), 32'd0);
    check("rx_bal2",    32'(balance), 32'd1000);

    // Full contention with balance inquiries: order 0,1,2,3,0 every 3 cycles
    op  = 8'b01010101;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      check("rr_grant", 32'(grant), 32'(4'b1 << (g % 4)));
      tick();
      exp_cnt++;
      check("rr_done",   32'(done), 32'd1);
      check("rr_status", 32'(status), 32'd0);
      check("rr_bal",    32'(rsp_balance), 32'd1000);
      check("rr_cnt",    32'(txn_count), 32'(cnt_exp()));
      tick();
      check("rr_gap", 32'(grant), 32'd0);
    end
    req = 4'b0;
    tick();
    check("end_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
